// File: rtl/reg_file.sv
// General-purpose register file with Zero/shift-carry status register for the
// single-cycle ALU datapath; combinational reads with optional write-first forwarding.
module reg_file #(
  parameter int unsigned W      = 8,
  parameter int unsigned A      = 3,
  parameter bit          BYPASS = 1'b0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         WriteEn,
  input  logic [A-1:0] Waddr,
  input  logic [W-1:0] DataIn,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  input  logic         FlagWe,
  input  logic         ZeroIn,
  input  logic         ScNext,
  output logic         ZeroFlag,
  output logic         SC_out
);

  localparam int unsigned DEPTH = 2 ** A;

  logic [DEPTH-1:0][W-1:0] regs_q, regs_d;
  logic                    zero_q, zero_d;
  logic                    sc_q, sc_d;
  logic                    fwd_a_c, fwd_b_c;

  // Next-state: one decoded register entry and the status pair.
  always_comb begin
    regs_d = regs_q;
    zero_d = zero_q;
    sc_d   = sc_q;
    if (WriteEn) begin
      regs_d[Waddr] = DataIn;
    end
    if (FlagWe) begin
      zero_d = ZeroIn;
      sc_d   = ScNext;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regs_q <= '0;
      zero_q <= 1'b0;
      sc_q   <= 1'b0;
    end else begin
      regs_q <= regs_d;
      zero_q <= zero_d;
      sc_q   <= sc_d;
    end
  end

  // Forwarding is suppressed during reset so reads stay at zero.
  assign fwd_a_c = BYPASS && WriteEn && !Reset && (RaddrA == Waddr);
  assign fwd_b_c = BYPASS && WriteEn && !Reset && (RaddrB == Waddr);

  assign DataOutA = fwd_a_c ? DataIn : regs_q[RaddrA];
  assign DataOutB = fwd_b_c ? DataIn : regs_q[RaddrB];
  assign ZeroFlag = zero_q;
  assign SC_out   = sc_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed and randomized checks of reg_file, with one instance per BYPASS
// setting driven in parallel and compared against an array-based reference.
module tb_reg_file;

  logic       Clk;
  logic       Reset;
  logic       WriteEn;
  logic [2:0] Waddr;
  logic [7:0] DataIn;
  logic [2:0] RaddrA, RaddrB;
  logic       FlagWe, ZeroIn, ScNext;
  logic [7:0] a0, b0, a1, b1;
  logic       zf0, sc0, zf1, sc1;

  reg_file #(.W(8), .A(3), .BYPASS(1'b0)) u_b0 (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(a0), .DataOutB(b0),
    .FlagWe(FlagWe), .ZeroIn(ZeroIn), .ScNext(ScNext), .ZeroFlag(zf0), .SC_out(sc0)
  );

  reg_file #(.W(8), .A(3), .BYPASS(1'b1)) u_b1 (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(a1), .DataOutB(b1),
    .FlagWe(FlagWe), .ZeroIn(ZeroIn), .ScNext(ScNext), .ZeroFlag(zf1), .SC_out(sc1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [7:0] mdl [8];
  logic       m_zf, m_sc;
  int         n_total = 0;
  int         n_pass  = 0;
  int         n_fail  = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference read: registered value, or write data when forwarding applies.
  function automatic logic [7:0] exp_rd(input bit byp, input logic [2:0] ra);
    if (Reset) return 8'h00;
    if (byp && WriteEn && ra == Waddr) return DataIn;
    return mdl[ra];
  endfunction

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] x,
                                     input logic [7:0] y, input logic sci);
    case (op)
      3'b000:  return x + y;
      3'b001:  return {x[6:0], sci};
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".A0"}, a0, exp_rd(1'b0, RaddrA));
    chk({tag, ".B0"}, b0, exp_rd(1'b0, RaddrB));
    chk({tag, ".A1"}, a1, exp_rd(1'b1, RaddrA));
    chk({tag, ".B1"}, b1, exp_rd(1'b1, RaddrB));
    chk({tag, ".ZF"}, {6'd0, zf1, zf0}, {6'd0, m_zf, m_zf});
    chk({tag, ".SC"}, {6'd0, sc1, sc0}, {6'd0, m_sc, m_sc});
  endtask

  // Advance one clock edge, updating the reference with what the edge commits.
  task automatic step();
    @(posedge Clk);
    if (!Reset) begin
      if (WriteEn) mdl[Waddr] = DataIn;
      if (FlagWe) begin
        m_zf = ZeroIn;
        m_sc = ScNext;
      end
    end
    @(negedge Clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    m_zf = 1'b0;
    m_sc = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [7:0] d);
    WriteEn = 1'b1; Waddr = addr; DataIn = d;
    step();
    WriteEn = 1'b0;
  endtask

  logic [7:0] alu_out;

  initial begin
    Reset = 1'b0; WriteEn = 1'b0; Waddr = '0; DataIn = '0;
    RaddrA = '0; RaddrB = '0; FlagWe = 1'b0; ZeroIn = 1'b0; ScNext = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 8'hxx;
    m_zf = 1'bx; m_sc = 1'bx;

    // Reset state on every address
    #2 Reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 8; i++) begin
      RaddrA = 3'(i); RaddrB = 3'(7 - i);
      #1 check_all("rst");
      chk("rst.A0.zero", a0, 8'h00);
    end
    @(negedge Clk);
    Reset = 1'b0;
    #1 check_all("rst_rel");

    // Basic writes, then ALU ADD into r6
    @(negedge Clk);
    wr(3'd3, 8'hA5);
    wr(3'd5, 8'h3C);
    RaddrA = 3'd3; RaddrB = 3'd5;
    #1 check_all("rd35");
    chk("rd3.const", a0, 8'hA5);
    chk("rd5.const", b1, 8'h3C);
    alu_out = alu(3'b000, mdl[3], mdl[5], m_sc);
    @(negedge Clk);
    wr(3'd6, alu_out);
    RaddrA = 3'd6; RaddrB = 3'd6;
    #1 check_all("rd6");
    chk("rd6.const", a0, 8'hE1);

    // Same-cycle read/write hazard on r2
    @(negedge Clk);
    wr(3'd2, 8'h11);
    WriteEn = 1'b1; Waddr = 3'd2; DataIn = 8'h77; RaddrA = 3'd2; RaddrB = 3'd5;
    #1 check_all("haz_pre");
    chk("haz_pre.b0", a0, 8'h11);
    chk("haz_pre.b1", a1, 8'h77);
    @(negedge Clk);
    step();
    WriteEn = 1'b0;
    #1 check_all("haz_post");
    chk("haz_post.b0", a0, 8'h77);

    // Flags set, then hold, then LSH with carry in
    @(negedge Clk);
    FlagWe = 1'b1; ZeroIn = 1'b1; ScNext = 1'b1;
    step();
    FlagWe = 1'b0; ZeroIn = 1'b0; ScNext = 1'b0;
    #1 check_all("flag_set");
    chk("flag_set.zf", {7'd0, zf0}, 8'h01);
    chk("flag_set.sc", {7'd0, sc1}, 8'h01);
    @(negedge Clk);
    step();
    #1 check_all("flag_hold");
    chk("flag_hold.zf", {7'd0, zf1}, 8'h01);
    @(negedge Clk);
    wr(3'd0, 8'h08);
    alu_out = alu(3'b001, mdl[0], 8'h00, m_sc);
    @(negedge Clk);
    wr(3'd4, alu_out);
    RaddrA = 3'd4; RaddrB = 3'd0;
    #1 check_all("lsh");
    chk("lsh.const", a1, 8'h11);

    // Async reset between edges, concurrent with a pending write
    @(negedge Clk);
    wr(3'd7, 8'hFF);
    RaddrA = 3'd7; RaddrB = 3'd7;
    #1 check_all("r7_ff");
    @(negedge Clk);
    WriteEn = 1'b1; Waddr = 3'd7; DataIn = 8'h42;
    #2 Reset = 1'b1;
    model_reset();
    #1 check_all("arst_now");
    chk("arst_now.b1", a1, 8'h00);
    @(negedge Clk);
    step();
    WriteEn = 1'b0;
    Reset = 1'b0;
    #1 check_all("arst_after");
    chk("arst_after.r7", b0, 8'h00);
    chk("arst_after.zf", {7'd0, zf0}, 8'h00);
    @(negedge Clk);
    step();
    #1 check_all("arst_after2");

    // Randomized sweep
    for (int c = 0; c < 200; c++) begin
      @(negedge Clk);
      WriteEn = 1'($urandom_range(0, 1));
      Waddr   = 3'($urandom_range(0, 7));
      DataIn  = 8'($urandom);
      RaddrA  = ($urandom_range(0, 3) == 0) ? Waddr : 3'($urandom_range(0, 7));
      RaddrB  = ($urandom_range(0, 3) == 0) ? Waddr : 3'($urandom_range(0, 7));
      FlagWe  = 1'($urandom_range(0, 1));
      ZeroIn  = 1'($urandom_range(0, 1));
      ScNext  = 1'($urandom_range(0, 1));
      #1 check_all("rand");
      step();
    end
    WriteEn = 1'b0; FlagWe = 1'b0;
    #1 check_all("rand_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
